// File: rtl/index_adder_pkg.sv
// Shared definitions for the pipelined index adder: operation/mode encodings
// and the width of one packed pipeline stage record.
package index_adder_pkg;

  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_SUB    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // A stage record is {v, s[width], flag, tag[tag_w]}. The record typedef
  // itself lives in the top because its field widths are module parameters.
  function automatic int stage_bits(input int width, input int tag_w);
    return 1 + width + 1 + tag_w;
  endfunction

endpackage

// File: rtl/index_adder_stage.sv
// One register stage of the adder pipeline. It holds a packed stage record,
// loads it when enabled and clears it on synchronous reset.
module index_adder_stage #(
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;

  // Hold unless the pipeline advances.
  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  // Stage register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/index_adder_pipe.sv
// Pipelined index adder: add/subtract with wrap or saturate, tag passthrough,
// valid/ready handshake. A stall freezes every stage, bubbles are kept.
module index_adder_pipe
  import index_adder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sat,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_flag,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = stage_bits(WIDTH, TAG_W);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] s;
    logic             flag;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // Stage 0: extended add/sub, flag is carry (add) or borrow (sub) taken
  // before saturation so the consumer can still see that it clipped.
  function automatic stage_t stage0_calc(
    input logic             v,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sub,
    input logic             sat,
    input logic [TAG_W-1:0] tag
  );
    logic [WIDTH:0] ext;
    stage_t         r;
    if (sub == OP_SUB) ext = {1'b0, a} - {1'b0, b};
    else               ext = {1'b0, a} + {1'b0, b};
    r.v    = v;
    r.flag = ext[WIDTH];
    r.tag  = tag;
    r.s    = ext[WIDTH-1:0];
    if (sat == MODE_SAT && r.flag) r.s = (sub == OP_SUB) ? '0 : '1;
    return r;
  endfunction

  logic [SW-1:0] stage_d [LATENCY];
  logic [SW-1:0] stage_q [LATENCY];
  stage_t        out_st;
  logic          advance;

  assign stage_d[0] = stage0_calc(in_valid, in_a, in_b, in_sub, in_sat, in_tag);

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stage_d[k] = stage_q[k-1];
    end
    index_adder_stage #(.DW(SW)) u_stage (
      .clk   (clk),
      .reset (reset),
      .en_i  (advance),
      .d_i   (stage_d[k]),
      .q_o   (stage_q[k])
    );
  end

  assign out_st    = stage_t'(stage_q[LATENCY-1]);
  assign out_valid = out_st.v;
  assign out_s     = out_st.s;
  assign out_flag  = out_st.flag;
  assign out_tag   = out_st.tag;

  // The whole pipe moves only when the last stage is empty or being taken;
  // ce=0 blocks the handshake even if the consumer is ready.
  assign advance  = ce & (~out_valid | out_ready);
  assign in_ready = advance;

endmodule

// File: tb/tb_index_adder_pipe.sv
// Self-checking bench for index_adder_pipe (WIDTH=8, LATENCY=3, TAG_W=4).
module tb_index_adder_pipe;

  localparam int W   = 8;
  localparam int LAT = 3;
  localparam int TW  = 4;

  logic          clk = 1'b0;
  logic          reset, ce, in_valid, in_ready, in_sub, in_sat;
  logic [W-1:0]  in_a, in_b, out_s;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_valid, out_ready, out_flag;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int s;
    bit f;
    int tag;
    int age;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  index_adder_pipe #(.WIDTH(W), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_sat    (in_sat),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_flag  (out_flag),
    .out_tag   (out_tag)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic void model(input int a, input int b, input bit sub, input bit sat,
                                output int s, output bit f);
    int r;
    if (!sub) begin
      r = a + b;
      f = (r > 255);
      s = (f && sat) ? 255 : r % 256;
    end else begin
      f = (a < b);
      s = (f && sat) ? 0 : (a - b + 256) % 256;
    end
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  int snap;
  bit hold_pending = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      bit adv, exp_ov;
      adv = ce & (~out_valid | out_ready);
      chk("in_ready", int'(in_ready), int'(adv));
      if (reset) begin
        sb.delete();
        hold_pending = 1'b0;
      end else begin
        if (hold_pending)
          chk("hold", int'({out_valid, out_s, out_flag, out_tag}), snap);
        exp_ov = (sb.size() > 0) && (sb[0].age == LAT);
        chk("out_valid", int'(out_valid), int'(exp_ov));
        if (out_valid && sb.size() > 0) begin
          chk("out_s", int'(out_s), sb[0].s);
          chk("out_flag", int'(out_flag), int'(sb[0].f));
          chk("out_tag", int'(out_tag), sb[0].tag);
        end
        if (adv) begin
          if (out_valid && sb.size() > 0) void'(sb.pop_front());
          foreach (sb[i]) sb[i].age++;
          if (in_valid) begin
            exp_t e;
            model(int'(in_a), int'(in_b), in_sub, in_sat, e.s, e.f);
            e.tag = int'(in_tag);
            e.age = 1;
            sb.push_back(e);
          end
        end
        hold_pending = out_valid & ~(out_ready & ce);
        snap = int'({out_valid, out_s, out_flag, out_tag});
      end
    end
  end

  task automatic drive(input int a, input int b, input bit sub, input bit sat, input int tag);
    in_valid = 1'b1;
    in_a     = a[W-1:0];
    in_b     = b[W-1:0];
    in_sub   = sub;
    in_sat   = sat;
    in_tag   = tag[TW-1:0];
  endtask

  // Present a transaction and return just after the edge that accepts it.
  task automatic send(input int a, input int b, input bit sub, input bit sat, input int tag);
    int n = 0;
    drive(a, b, sub, sat, tag);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int a, input int b, input bit sub, input bit sat, input int tag,
                        input int es, input int ef, input string name);
    send(a, b, sub, sat, tag);
    in_valid = 1'b0;
    chk({name, "_lat1"}, int'(out_valid), 0);
    @(posedge clk); #1;
    chk({name, "_lat2"}, int'(out_valid), 0);
    @(posedge clk); #1;
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_s"}, int'(out_s), es);
    chk({name, "_flag"}, int'(out_flag), ef);
    chk({name, "_tag"}, int'(out_tag), tag);
    @(posedge clk); #1;
  endtask

  initial begin
    int ms;
    bit mf;
    int snap_ce;

    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ms;
    bit mf;
    int snap_ce;

    reset = 1'b1; ce = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_sat = 1'b0; in_tag = '0;

    model(200, 100, 1'b0, 1'b0, ms, mf);
    chk("model_add_wrap", ms, 44);
    model(10, 20, 1'b1, 1'b0, ms, mf);
    chk("model_sub_wrap", ms, 246);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_s", int'(out_s), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    mon_en = 1'b1;

    single(200, 100, 1'b0, 1'b0, 5, 44, 1, "add_wrap");
    single(200, 100, 1'b0, 1'b1, 6, 255, 1, "add_sat");
    single(10, 20, 1'b1, 1'b1, 7, 0, 1, "sub_sat");
    single(10, 20, 1'b1, 1'b0, 8, 246, 1, "sub_wrap");
    single(100, 27, 1'b1, 1'b1, 9, 73, 0, "sub_nob");

    // Back-to-back stream, tags 0..7.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(c * 30, 255 - c * 17, c[0], c[1], c);
      else in_valid = 1'b0;
      @(posedge clk); #1;
      chk("stream_in_ready", int'(in_ready), 1);
      chk("stream_valid", int'(out_valid), (c >= 2 && c <= 9) ? 1 : 0);
      if (c >= 2 && c <= 9) chk("stream_tag", int'(out_tag), c - 2);
    end

    // Three in flight, then consumer stalls for 4 cycles.
    for (int c = 0; c < 3; c++) begin
      drive(50 + c, 3, 1'b0, 1'b0, 8 + c);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    drive(1, 2, 1'b1, 1'b0, 11);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_tag", int'(out_tag), 8);
      chk("stall_s", int'(out_s), 53);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("drain_tag9", int'(out_tag), 9);
    @(posedge clk); #1;
    chk("drain_tag10", int'(out_tag), 10);
    @(posedge clk); #1;
    chk("drain_tag11", int'(out_tag), 11);
    chk("drain_s11", int'(out_s), 255);
    @(posedge clk); #1;
    chk("drain_empty", int'(out_valid), 0);

    // Clock-enable freeze mid-stream.
    fork
      begin
        for (int t = 0; t < 6; t++) send(t * 40, t * 25 + 1, t[0], 1'b0, (12 + t) % 16);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        ce = 1'b0;
        snap_ce = int'({out_valid, out_s, out_flag, out_tag});
        chk("ce_snap_valid", int'(out_valid), 1);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk("ce_in_ready", int'(in_ready), 0);
          @(posedge clk); #1;
          chk("ce_frozen", int'({out_valid, out_s, out_flag, out_tag}), snap_ce);
        end
        ce = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1 chk("ce_sb_empty", sb.size(), 0);

    // Reset with two results in flight.
    send(3, 4, 1'b0, 1'b0, 2);
    send(9, 1, 1'b1, 1'b0, 3);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_s", int'(out_s), 0);
    chk("mid_rst_flag", int'(out_flag), 0);
    chk("mid_rst_tag", int'(out_tag), 0);
    for (int k = 0; k < LAT + 1; k++) begin
      @(posedge clk); #1;
      chk("no_stale", int'(out_valid), 0);
    end

    single(255, 1, 1'b0, 1'b0, 4, 0, 1, "post_rst");
    repeat (2) @(posedge clk);
    #1 chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/index_adder_pipe.md
Name: index_adder_pipe

Overview:
Parametrised pipelined index adder, successor to the fixed 8-bit, single-cycle, toggling-valid adder wrapper.
- Configurable width and latency; add or subtract per transaction; wrap or saturate; tag passthrough.
- Valid/ready handshake with full-pipeline stall; a valid bit tracks every stage.
- Sits between index generators and memory/address consumers in the datapath.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
LATENCY, 1, input-accept to out_valid cycles (>=1); number of register stages
TAG_W, 4, width of the sideband tag carried alongside each operation (>=1)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
ce  in  1  global clock enable; 0 freezes every stage
in_valid  in  1  operands present
in_ready  out  1  block accepts this cycle
in_a  in  WIDTH  operand A, unsigned
in_b  in  WIDTH  operand B, unsigned
in_sub  in  1  0: A+B, 1: A-B
in_sat  in  1  0: wrap modulo 2^WIDTH, 1: saturate
in_tag  in  TAG_W  sideband, returned unchanged with the result
out_valid  out  1  result present at last stage
out_ready  in  1  consumer accepts
out_s  out  WIDTH  result
out_flag  out  1  carry out (add) or borrow (sub), pre-saturation
out_tag  out  TAG_W  tag of this result

Behaviour:
- Stage 0 is combinational on the input: ext = {0,A} +/- {0,B}, WIDTH+1 bits; flag = ext[WIDTH].
- Result selection:
  - in_sat=0: S = ext[WIDTH-1:0].
  - in_sat=1, add with flag=1: S = all ones.
  - in_sat=1, sub with flag=1: S = 0.
- Stage k (1..LATENCY) holds {v, s, flag, tag}. Stage LATENCY drives the out_* ports directly from registers.
- advance = ce & (~out_valid | out_ready); in_ready = advance (combinational, no dependency on in_valid).
- When advance=1:
  - every stage shifts one step;
  - stage 1 loads {in_valid, result, flag, in_tag};
  - bubbles propagate as v=0;
  - data registers load regardless of v (don't-care when v=0).
- When advance=0: all stages hold, including valid bits.
- Pipeline bubbles are not collapsed. A stall freezes the whole pipe.
- Accepted transaction: in_valid & in_ready. It appears on out_* exactly LATENCY advancing cycles later; with ce=1 and out_ready=1 this is exactly LATENCY clocks.
- Throughput: one result per cycle while advance=1; no bubble insertion.
- Output hold rule: out_valid, out_s, out_flag and out_tag stay stable while out_valid=1 and out_ready=0.
- ce=0 overrides out_ready: out_valid holds and no handshake completes, even if out_ready=1.
- Reset (synchronous, priority over ce and advance):
  - all stage valid bits clear; all data registers clear to 0;
  - next cycle: out_valid=0, out_s=0, out_flag=0, out_tag=0;
  - in_ready follows advance from the next cycle (ce-dependent);
  - reset mid-stream discards in-flight results with no partial output.
- in_valid=1 with in_ready=0: the input is not captured; the producer must hold it.
- LATENCY=1: a single register stage. in_ready = ce & (~out_valid | out_ready).

Decomposition:
- Shared package index_adder_pkg:
  - stage record typedef {v, s[WIDTH], flag, tag[TAG_W]}, parametrised via function or macro widths;
  - mode constants OP_ADD=0, OP_SUB=1, MODE_WRAP=0, MODE_SAT=1.
- One sub-module, index_adder_stage: a single register stage with enable and synchronous reset, instantiated LATENCY times in a generate loop.
- The stage-0 arithmetic/saturation function lives in the top module.

Test Plan:
- WIDTH=8, LATENCY=3, ce=1, out_ready=1. Send A=200, B=100, add, wrap, tag=5 -> out_valid exactly 3 clocks later with out_s=44, out_flag=1, out_tag=5.
- Same operands with in_sat=1 -> out_s=255, out_flag=1. Then A=10, B=20, sub, sat -> out_s=0, flag=1. Then sub, wrap -> out_s=246, flag=1.
- Back-to-back stream of 8 transactions with tags 0..7, out_ready=1 -> 8 consecutive out_valid cycles, tags in order, in_ready constant 1.
- With 3 results in flight, drop out_ready for 4 cycles -> in_ready=0, out_* frozen on the first result. Raise out_ready -> remaining results follow in order with no loss or duplication.
- ce=0 for 2 cycles mid-stream, with out_ready=1 -> no stage moves, out_valid held, in_ready=0; the stream resumes intact.
- Assert reset for 1 cycle with 2 results in flight -> next cycle out_valid=0, out_s=0. No stale result emerges in the following LATENCY cycles.
